ball_motion_controller: RTL

//  Consumer end of the wall-hit flag: owns ball position/direction, renders ball video.

---
 rtl/ball_motion_controller.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ball_motion_controller.sv
// Ball position/direction owner: steps the ball once per frame, reverses X on wall hits,
// bounces Y at the screen edges and renders a registered ball-video pixel flag.
module ball_motion_controller #(
  parameter int CW           = 10,
  parameter int ACTIVE_W     = 640,
  parameter int ACTIVE_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int STEP         = 2,
  parameter int START_X      = 316,
  parameter int START_Y      = 236,
  parameter int SERVE_FRAMES = 60,
  parameter int HOLD_FRAMES  = 4
) (
  input  logic          i_Clk,
  input  logic          i_Reset,
  input  logic [CW-1:0] i_HCount,
  input  logic [CW-1:0] i_VCount,
  input  logic          i_VReset,
  input  logic          i_Hit,
  output logic          o_Ball_Video,
  output logic [CW-1:0] o_Ball_X,
  output logic [CW-1:0] o_Ball_Y,
  output logic          o_Dir_X,
  output logic          o_Dir_Y,
  output logic          o_Bounce
);

  typedef enum logic [1:0] {SERVE, RUN, HOLD} state_t;

  localparam logic [CW:0]   STEP_W = (CW+1)'(STEP);
  localparam logic [CW:0]   SIZE_W = (CW+1)'(BALL_SIZE);
  localparam logic [CW:0]   X_MAX  = (CW+1)'(ACTIVE_W - BALL_SIZE);
  localparam logic [CW:0]   Y_MAX  = (CW+1)'(ACTIVE_H - BALL_SIZE);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_FRAMES - 1);

  state_t        state, state_next;
  logic [CW-1:0] frame_cnt, frame_cnt_next;
  logic [CW-1:0] x, x_next, y, y_next;
  logic          dir_x, dir_x_next, dir_y, dir_y_next;
  logic          dx;
  logic [CW:0]   x_step, y_step;
  logic          in_ball;

  // One axis step in CW+1 bits; result is {new_dir, new_pos}, clamping and reversing at the edges.
  function automatic logic [CW:0] step_axis(input logic [CW-1:0] pos, input logic dir,
                                            input logic [CW:0] lim);
    logic [CW:0] ext;
    logic [CW:0] sum;
    logic [CW:0] diff;
    ext  = {1'b0, pos};
    sum  = ext + STEP_W;
    diff = ext - STEP_W;
    if (dir) begin
      if (sum > lim) step_axis = {1'b0, lim[CW-1:0]};
      else           step_axis = {1'b1, sum[CW-1:0]};
    end else begin
      if (ext < STEP_W) step_axis = {1'b1, {CW{1'b0}}};
      else              step_axis = {1'b0, diff[CW-1:0]};
    end
  endfunction

  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    x_next         = x;
    y_next         = y;
    dir_x_next     = dir_x;
    dir_y_next     = dir_y;
    dx             = dir_x;
    x_step         = '0;
    y_step         = '0;
    if (i_VReset) begin
      case (state)
        SERVE: begin
          if (frame_cnt == SERVE_LAST) begin
            state_next     = RUN;
            frame_cnt_next = '0;
          end else begin
            frame_cnt_next = frame_cnt + 1'b1;
          end
        end
        RUN, HOLD: begin
          if (state == RUN && i_Hit) begin
            dx             = ~dir_x;
            state_next     = HOLD;
            frame_cnt_next = '0;
          end else if (state == HOLD) begin
            if (frame_cnt == HOLD_LAST) begin
              state_next     = RUN;
              frame_cnt_next = '0;
            end else begin
              frame_cnt_next = frame_cnt + 1'b1;
            end
          end
          // The clamp test sees the post-hit direction, so an axis reverses at most once per tick.
          x_step     = step_axis(x, dx, X_MAX);
          y_step     = step_axis(y, dir_y, Y_MAX);
          x_next     = x_step[CW-1:0];
          dir_x_next = x_step[CW];
          y_next     = y_step[CW-1:0];
          dir_y_next = y_step[CW];
        end
        default: state_next = SERVE;
      endcase
    end
  end

  always_comb begin
    in_ball = ({1'b0, i_HCount} >= {1'b0, x}) && ({1'b0, i_HCount} < {1'b0, x} + SIZE_W) &&
              ({1'b0, i_VCount} >= {1'b0, y}) && ({1'b0, i_VCount} < {1'b0, y} + SIZE_W);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state        <= SERVE;
      frame_cnt    <= '0;
      x            <= CW'(START_X);
      y            <= CW'(START_Y);
      dir_x        <= 1'b1;
      dir_y        <= 1'b1;
      o_Bounce     <= 1'b0;
      o_Ball_Video <= 1'b0;
    end else begin
      state        <= state_next;
      frame_cnt    <= frame_cnt_next;
      x            <= x_next;
      y            <= y_next;
      dir_x        <= dir_x_next;
      dir_y        <= dir_y_next;
      o_Bounce     <= (dir_x_next != dir_x) || (dir_y_next != dir_y);
      o_Ball_Video <= in_ball;
    end
  end

  assign o_Ball_X = x;
  assign o_Ball_Y = y;
  assign o_Dir_X  = dir_x;
  assign o_Dir_Y  = dir_y;

endmodule
